divisor_periph_n: RTL and testbench

- Parametrised memory-mapped integer divider peripheral on the processor's `cs`/`addr`/`rd`/`wr` bus.
- Successor to the fixed 16-bit divider peripheral.
- Integrated iterative restoring divider, one quotient bit per cycle.
- Adds: quotient and remainder outputs, signed/unsigned mode, divide-by-zero and overflow flags, BUSY status, self-clearing START, operand snapshot, interrupt output.

---
 rtl/divisor_periph_n.sv | 200 ++++++++++++++++++++
 tb/tb_divisor_periph_n.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/divisor_periph_n.sv
// Memory-mapped iterative restoring divider: one quotient bit per clock, with
// signed/unsigned modes, divide-by-zero and overflow shortcuts, and an interrupt.
module divisor_periph_n #(
  parameter int WIDTH = 16,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             CLK,
  input  logic             reset,
  input  logic [WIDTH-1:0] d_in,
  input  logic             cs,
  input  logic [4:0]       addr,
  input  logic             rd,
  input  logic             wr,
  output logic [WIDTH-1:0] d_out,
  output logic             irq
);

  localparam logic [4:0] A_DV     = 5'h04;
  localparam logic [4:0] A_DR     = 5'h08;
  localparam logic [4:0] A_CTRL   = 5'h0C;
  localparam logic [4:0] A_Q      = 5'h10;
  localparam logic [4:0] A_STATUS = 5'h14;
  localparam logic [4:0] A_REM    = 5'h18;

  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX} state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   dv_q, dv_d, dr_q, dr_d;
  logic               ctrl_signed_q, ctrl_signed_d, ctrl_irq_en_q, ctrl_irq_en_d;
  logic [WIDTH-1:0]   q_q, q_d, rem_q, rem_d;
  logic               done_q, done_d, div0_q, div0_d, ovf_q, ovf_d;
  logic [WIDTH-1:0]   dout_q, dout_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   prem_q, prem_d, acc_q, acc_d, dmag_q, dmag_d;
  logic               quot_neg_q, quot_neg_d, rem_neg_q, rem_neg_d;

  logic               wr_en, rd_en, busy, accept, op_signed, is_zero, is_ovf;
  logic [WIDTH-1:0]   dv_abs, dr_abs, rd_data;
  logic [WIDTH:0]     shifted, diff;

  assign wr_en     = cs & wr;
  assign rd_en     = cs & rd;
  assign busy      = (state_q != S_IDLE);
  // SIGNED comes from the same write that carries START, so CTRL=0x3 runs signed.
  assign op_signed = d_in[1];
  assign accept    = wr_en && (addr == A_CTRL) && d_in[0] && !busy;
  assign is_zero   = (dr_q == '0);
  assign is_ovf    = op_signed && (dv_q == MOST_NEG) && (dr_q == '1);
  assign dv_abs    = (op_signed && dv_q[WIDTH-1]) ? -dv_q : dv_q;
  assign dr_abs    = (op_signed && dr_q[WIDTH-1]) ? -dr_q : dr_q;

  assign shifted   = {prem_q, acc_q[WIDTH-1]};
  assign diff      = shifted - {1'b0, dmag_q};

  assign irq       = done_q & ctrl_irq_en_q;
  assign d_out     = dout_q;

  // NOTE: state holds only through non-blocking assignments in clocked blocks,
  // so every register samples the same pre-edge values.
  always_ff @(posedge CLK) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (accept && !is_zero && !is_ovf) state_d = S_CALC;
      S_CALC: if (cnt_q == CNT_W'(1))             state_d = S_FIX;
      S_FIX:                                      state_d = S_IDLE;
      default:                                    state_d = S_IDLE;
    endcase
  end

  always_comb begin
    rd_data = '0;
    unique case (addr)
      A_DV:     rd_data = dv_q;
      A_DR:     rd_data = dr_q;
      A_CTRL:   rd_data[2:1] = {ctrl_irq_en_q, ctrl_signed_q};
      A_Q:      rd_data = q_q;
      A_STATUS: rd_data[3:0] = {ovf_q, div0_q, busy, done_q};
      A_REM:    rd_data = rem_q;
      default:  rd_data = '0;
    endcase
  end

  // NOTE: every target gets a hold value first, so no path through this block
  // leaves a signal unassigned and no latch is inferred.
  always_comb begin
    dv_d          = dv_q;
    dr_d          = dr_q;
    ctrl_signed_d = ctrl_signed_q;
    ctrl_irq_en_d = ctrl_irq_en_q;
    q_d           = q_q;
    rem_d         = rem_q;
    done_d        = done_q;
    div0_d        = div0_q;
    ovf_d         = ovf_q;
    cnt_d         = cnt_q;
    prem_d        = prem_q;
    acc_d         = acc_q;
    dmag_d        = dmag_q;
    quot_neg_d    = quot_neg_q;
    rem_neg_d     = rem_neg_q;
    dout_d        = rd_en ? rd_data : dout_q;

    if (wr_en) begin
      if (addr == A_DV) dv_d = d_in;
      if (addr == A_DR) dr_d = d_in;
      if (addr == A_CTRL) begin
        ctrl_signed_d = d_in[1];
        ctrl_irq_en_d = d_in[2];
      end
    end

    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          done_d = 1'b0;
          div0_d = 1'b0;
          ovf_d  = 1'b0;
          if (is_zero) begin
            q_d    = '1;
            rem_d  = dv_q;
            div0_d = 1'b1;
            done_d = 1'b1;
          end else if (is_ovf) begin
            q_d    = MOST_NEG;
            rem_d  = '0;
            ovf_d  = 1'b1;
            done_d = 1'b1;
          end else begin
            prem_d     = '0;
            acc_d      = dv_abs;
            dmag_d     = dr_abs;
            cnt_d      = CNT_W'(WIDTH);
            quot_neg_d = op_signed & (dv_q[WIDTH-1] ^ dr_q[WIDTH-1]);
            rem_neg_d  = op_signed & dv_q[WIDTH-1];
          end
        end
      end
      S_CALC: begin
        // Restore by keeping the shifted value when the trial subtract borrows.
        prem_d = diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
        acc_d  = {acc_q[WIDTH-2:0], ~diff[WIDTH]};
        cnt_d  = cnt_q - CNT_W'(1);
      end
      S_FIX: begin
        q_d    = quot_neg_q ? -acc_q : acc_q;
        rem_d  = rem_neg_q ? -prem_q : prem_q;
        done_d = 1'b1;
      end
      default: ;
    endcase
  end

  // NOTE: the working registers are reset too, so an aborted division leaves
  // no stale partial result behind.
  always_ff @(posedge CLK) begin
    if (reset) begin
      dv_q          <= '0;
      dr_q          <= '0;
      ctrl_signed_q <= 1'b0;
      ctrl_irq_en_q <= 1'b0;
      q_q           <= '0;
      rem_q         <= '0;
      done_q        <= 1'b0;
      div0_q        <= 1'b0;
      ovf_q         <= 1'b0;
      dout_q        <= '0;
      cnt_q         <= '0;
      prem_q        <= '0;
      acc_q         <= '0;
      dmag_q        <= '0;
      quot_neg_q    <= 1'b0;
      rem_neg_q     <= 1'b0;
    end else begin
      dv_q          <= dv_d;
      dr_q          <= dr_d;
      ctrl_signed_q <= ctrl_signed_d;
      ctrl_irq_en_q <= ctrl_irq_en_d;
      q_q           <= q_d;
      rem_q         <= rem_d;
      done_q        <= done_d;
      div0_q        <= div0_d;
      ovf_q         <= ovf_d;
      dout_q        <= dout_d;
      cnt_q         <= cnt_d;
      prem_q        <= prem_d;
      acc_q         <= acc_d;
      dmag_q        <= dmag_d;
      quot_neg_q    <= quot_neg_d;
      rem_neg_q     <= rem_neg_d;
    end
  end

endmodule

// File: tb/tb_divisor_periph_n.sv
// Directed bench for divisor_periph_n: a reference model pushes expected Q/REM/STATUS
// into a scoreboard at START time; bus reads pop and compare once the operation is done.
module tb_divisor_periph_n;

  localparam int W = 16;
  localparam logic [4:0] A_DV     = 5'h04;
  localparam logic [4:0] A_DR     = 5'h08;
  localparam logic [4:0] A_CTRL   = 5'h0C;
  localparam logic [4:0] A_Q      = 5'h10;
  localparam logic [4:0] A_STATUS = 5'h14;
  localparam logic [4:0] A_REM    = 5'h18;
  localparam logic [4:0] A_UNMAP  = 5'h1C;

  logic         CLK = 1'b0;
  logic         reset = 1'b1;
  logic [W-1:0] d_in = '0;
  logic         cs = 1'b0;
  logic [4:0]   addr = '0;
  logic         rd = 1'b0;
  logic         wr = 1'b0;
  logic [W-1:0] d_out;
  logic         irq;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  typedef struct {
    string        tag;
    logic [4:0]   addr;
    logic [W-1:0] exp;
  } sb_t;
  sb_t sb[$];

  divisor_periph_n #(.WIDTH(W)) dut (
    .CLK   (CLK),
    .reset (reset),
    .d_in  (d_in),
    .cs    (cs),
    .addr  (addr),
    .rd    (rd),
    .wr    (wr),
    .d_out (d_out),
    .irq   (irq)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, required finish before time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
    end
  endtask

  // Bus tasks start and end at a falling edge and consume exactly one rising edge.
  task automatic bus_write(input logic [4:0] a, input logic [W-1:0] d);
    cs = 1'b1; wr = 1'b1; addr = a; d_in = d;
    @(posedge CLK);
    @(negedge CLK);
    cs = 1'b0; wr = 1'b0;
  endtask

  task automatic bus_read(input logic [4:0] a, output logic [W-1:0] d);
    cs = 1'b1; rd = 1'b1; addr = a;
    @(posedge CLK);
    @(negedge CLK);
    d = d_out;
    cs = 1'b0; rd = 1'b0;
  endtask

  task automatic read_check(input string tag, input logic [4:0] a, input logic [W-1:0] exp);
    logic [W-1:0] v;
    bus_read(a, v);
    check(tag, v, exp);
  endtask

  function automatic void push_expected(input string tag, input logic [W-1:0] dv,
                                        input logic [W-1:0] dr, input logic sgn);
    logic signed [W-1:0] sdv, sdr;
    logic [W-1:0] q, r, st;
    sdv = dv;
    sdr = dr;
    if (dr == '0) begin
      q = '1; r = dv; st = 16'h0005;
    end else if (sgn && dv == 16'h8000 && dr == 16'hFFFF) begin
      q = 16'h8000; r = '0; st = 16'h0009;
    end else if (sgn) begin
      q = sdv / sdr; r = sdv % sdr; st = 16'h0001;
    end else begin
      q = dv / dr; r = dv % dr; st = 16'h0001;
    end
    sb.push_back('{{tag, ".q"},      A_Q,      q});
    sb.push_back('{{tag, ".rem"},    A_REM,    r});
    sb.push_back('{{tag, ".status"}, A_STATUS, st});
  endfunction

  task automatic drain();
    while (sb.size() > 0) begin
      sb_t e;
      e = sb.pop_front();
      read_check(e.tag, e.addr, e.exp);
    end
  endtask

  task automatic start_op(input string tag, input logic [W-1:0] dv, input logic [W-1:0] dr,
                          input logic [W-1:0] ctrl, output int e0);
    bus_write(A_DV, dv);
    bus_write(A_DR, dr);
    bus_write(A_CTRL, ctrl);
    e0 = cyc;
    push_expected(tag, dv, dr, ctrl[1]);
  endtask

  // A read at edge N reports the state left by edge N-1.
  task automatic wait_done(input string tag, input int e0, input int lat);
    logic [W-1:0] s;
    int done_edge;
    done_edge = -1;
    for (int i = 0; i < 40; i++) begin
      bus_read(A_STATUS, s);
      if (s[0]) begin
        done_edge = cyc - 1;
        break;
      end
    end
    check(tag, done_edge - e0, lat);
  endtask

  initial begin
    int e0;
    int rise;
    logic [W-1:0] v;

    repeat (3) @(posedge CLK);
    @(negedge CLK);
    reset = 1'b0;

    check("rst.dout", d_out, 16'h0000);
    check("rst.irq", irq, 1'b0);
    read_check("rst.status", A_STATUS, 16'h0000);
    read_check("rst.dv", A_DV, 16'h0000);
    read_check("rst.ctrl", A_CTRL, 16'h0000);

    start_op("u100_7", 16'd100, 16'd7, 16'h0001, e0);
    read_check("u100_7.busy", A_STATUS, 16'h0002);
    wait_done("u100_7.lat", e0, 17);
    drain();

    start_op("sneg100_7", 16'hFF9C, 16'd7, 16'h0003, e0);
    wait_done("sneg100_7.lat", e0, 17);
    drain();
    read_check("ctrl.start_reads0", A_CTRL, 16'h0002);

    start_op("s100_neg7", 16'd100, 16'hFFF9, 16'h0003, e0);
    wait_done("s100_neg7.lat", e0, 17);
    drain();

    start_op("div0", 16'd1234, 16'd0, 16'h0001, e0);
    read_check("div0.e0p1", A_STATUS, 16'h0005);
    drain();

    start_op("ovf", 16'h8000, 16'hFFFF, 16'h0003, e0);
    read_check("ovf.e0p1", A_STATUS, 16'h0009);
    drain();

    start_op("busy1000_3", 16'd1000, 16'd3, 16'h0001, e0);
    while (cyc < e0 + 4) @(negedge CLK);
    bus_write(A_DR, 16'd9);
    bus_write(A_CTRL, 16'h0001);
    wait_done("busy1000_3.lat", e0, 17);
    drain();
    bus_write(A_CTRL, 16'h0001);
    e0 = cyc;
    push_expected("restart1000_9", 16'd1000, 16'd9, 1'b0);
    wait_done("restart1000_9.lat", e0, 17);
    drain();

    start_op("irq50_5", 16'd50, 16'd5, 16'h0005, e0);
    check("irq.low_after_start", irq, 1'b0);
    rise = -1;
    for (int i = 0; i < 40; i++) begin
      @(negedge CLK);
      if (irq) begin
        rise = cyc;
        break;
      end
    end
    check("irq.rise_edge", rise - e0, 17);
    drain();
    check("irq.high_held", irq, 1'b1);
    bus_write(A_CTRL, 16'h0000);
    check("irq.fall_after_en_clear", irq, 1'b0);
    read_check("irq.done_sticky", A_STATUS, 16'h0001);

    bus_write(A_CTRL, 16'h0005);
    repeat (3) @(negedge CLK);
    read_check("midop.busy", A_STATUS, 16'h0002);
    reset = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    reset = 1'b0;
    check("midrst.dout", d_out, 16'h0000);
    check("midrst.irq", irq, 1'b0);
    read_check("midrst.status", A_STATUS, 16'h0000);
    read_check("midrst.q", A_Q, 16'h0000);
    read_check("midrst.rem", A_REM, 16'h0000);
    repeat (20) @(negedge CLK);
    read_check("midrst.no_late_done", A_STATUS, 16'h0000);

    bus_write(A_DV, 16'hABCD);
    bus_write(A_UNMAP, 16'hFFFF);
    read_check("dv.readback", A_DV, 16'hABCD);
    read_check("unmapped.read", A_UNMAP, 16'h0000);
    bus_read(A_DR, v);
    check("unmapped.write_ignored", v, 16'h0000);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
